// File: rtl/cache_mem_arbiter.sv
// Single RAM port arbiter between the instruction and data caches.
// Data requests win; a saturating starvation counter forces an instruction grant.
module cache_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_err
);
    // state   | meaning
    // IDLE    | no grant; arbitrate between pending requests
    // SERVE_I | icache owns the RAM port until ACCESS or abort
    // SERVE_D | dcache owns the RAM port until ACCESS or abort
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [2:0] starve_cnt, starve_nxt;
    logic       dreq;

    assign dreq  = dREN | dWEN;
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            ram_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (state != IDLE && ramstate == RAM_ERROR)
                ram_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'd0;
        ramstore   = 32'd0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        case (state)
            IDLE: begin
                // starvation count only advances when a D grant passes over a waiting fetch
                if (iREN && (!dreq || starve_cnt == LIMIT)) begin
                    state_nxt  = SERVE_I;
                    starve_nxt = 3'd0;
                end else if (dreq) begin
                    state_nxt = SERVE_D;
                    if (iREN && starve_cnt < LIMIT)
                        starve_nxt = starve_cnt + 3'd1;
                end
            end
            SERVE_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (ramstate == RAM_ACCESS) begin
                    iwait     = 1'b0;
                    state_nxt = IDLE;
                end else if (!iREN) begin
                    state_nxt = IDLE;
                end
            end
            SERVE_D: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (ramstate == RAM_ACCESS) begin
                    dwait     = 1'b0;
                    state_nxt = IDLE;
                end else if (!dreq) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized bench for cache_mem_arbiter against an ownership-level model.
module tb_cache_mem_arbiter;
    localparam int LIMIT = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = FREE;
    logic        iwait, dwait, ramREN, ramWEN, ram_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int errors = 0;
    int checks = 0;

    // model: who owns the RAM port, consecutive D grants over a waiting fetch, sticky error
    int owner = 0;          // 0 none, 1 icache, 2 dcache
    int d_streak = 0;
    bit m_err = 1'b0;
    bit i_done = 1'b0, d_done = 1'b0;

    cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; d_streak = 0; m_err = 1'b0; i_done = 1'b0; d_done = 1'b0;
    endtask

    task automatic check_all();
        logic e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        if (owner == 1) begin
            e_ren = iREN; e_addr = iaddr;
        end else if (owner == 2) begin
            e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
        end
        e_iw = !(owner == 1 && ramstate == ACCESS);
        e_dw = !(owner == 2 && ramstate == ACCESS);
        chk("ramREN", 32'(ramREN), 32'(e_ren));
        chk("ramWEN", 32'(ramWEN), 32'(e_wen));
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("iwait", 32'(iwait), 32'(e_iw));
        chk("dwait", 32'(dwait), 32'(e_dw));
        chk("iload", iload, ramload);
        chk("dload", dload, ramload);
        chk("ram_err", 32'(ram_err), 32'(m_err));
    endtask

    task automatic model_step();
        i_done = 1'b0; d_done = 1'b0;
        if (owner == 0) begin
            if (iREN && (!(dREN || dWEN) || d_streak >= LIMIT)) begin
                owner = 1; d_streak = 0;
            end else if (dREN || dWEN) begin
                owner = 2;
                if (iREN && d_streak < LIMIT) d_streak++;
            end
        end else begin
            if (ramstate == ERR) m_err = 1'b1;
            if (ramstate == ACCESS) begin
                if (owner == 1) i_done = 1'b1; else d_done = 1'b1;
                owner = 0;
            end else if ((owner == 1 && !iREN) || (owner == 2 && !(dREN || dWEN))) begin
                owner = 0;
            end
        end
    endtask

    // inputs change at posedge+1, outputs checked at posedge+4
    task automatic tick();
        #3;
        check_all();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
        nRST = 1'b0; model_reset();
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    bit i_pend = 0, d_pend = 0;
    logic [31:0] exp_addr;

    initial begin
        // reset with both requesting
        iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200; nRST = 1'b0;
        #2;
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ram_err", 32'(ram_err), 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1; ramstate = ACCESS;
        tick();
        #3;
        chk("first_grant_d", ramaddr, 32'h200);
        chk("first_grant_dwait", 32'(dwait), 32'd0);
        #1;
        @(posedge CLK); model_step(); #1;

        // single fetch with 2 BUSY cycles
        do_reset();
        iREN = 1; iaddr = 32'h40; ramstate = BUSY;
        tick();
        #3; chk("fetch_addr_c2", ramaddr, 32'h40); chk("fetch_iwait_c2", 32'(iwait), 32'd1); #1;
        @(posedge CLK); model_step(); #1;
        tick();
        ramstate = ACCESS; ramload = 32'hEEEEAAAA;
        #3; chk("fetch_iwait_c4", 32'(iwait), 32'd0); chk("fetch_iload_c4", iload, 32'hEEEEAAAA); #1;
        @(posedge CLK); model_step(); #1;
        #3; chk("fetch_iwait_c5", 32'(iwait), 32'd1); #1;
        @(posedge CLK); model_step(); #1;
        iREN = 0;
        tick();

        // contention: expect D,D,D,D,I repeating
        do_reset();
        iREN = 1; dREN = 1; iaddr = 32'h1111; daddr = 32'h2222; ramstate = ACCESS;
        for (int g = 0; g < 10; g++) begin
            tick();
            exp_addr = ((g % 5) == 4) ? 32'h1111 : 32'h2222;
            #3; chk($sformatf("grant_%0d", g), ramaddr, exp_addr); #1;
            @(posedge CLK); model_step(); #1;
        end
        iREN = 0; dREN = 0;
        tick();

        // write wins over read
        do_reset();
        dREN = 1; dWEN = 1; daddr = 32'h00880020; dstore = 32'hDEADBEEF; ramstate = ACCESS;
        tick();
        #3;
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramstore", ramstore, 32'hDEADBEEF);
        chk("wr_dwait", 32'(dwait), 32'd0);
        #1;
        @(posedge CLK); model_step(); #1;
        dREN = 0; dWEN = 0;
        tick();

        // error retry then access
        do_reset();
        iREN = 1; iaddr = 32'h80; ramstate = FREE;
        tick();
        ramstate = ERR;
        for (int k = 0; k < 3; k++) begin
            #3; chk("err_iwait", 32'(iwait), 32'd1); chk("err_ramREN", 32'(ramREN), 32'd1); #1;
            @(posedge CLK); model_step(); #1;
            chk("err_sticky", 32'(ram_err), 32'd1);
        end
        ramstate = ACCESS;
        #3; chk("err_done_iwait", 32'(iwait), 32'd0); #1;
        @(posedge CLK); model_step(); #1;
        iREN = 0; ramstate = FREE;
        tick(); tick();
        chk("err_still_set", 32'(ram_err), 32'd1);

        // abort: iREN drops during SERVE_I
        do_reset();
        iREN = 1; iaddr = 32'hC0; ramstate = BUSY;
        tick();
        tick();
        iREN = 0;
        tick();
        iREN = 1;
        #3; chk("abort_idle_ramREN", 32'(ramREN), 32'd0); chk("abort_idle_addr", ramaddr, 32'd0); #1;
        @(posedge CLK); model_step(); #1;
        iREN = 0; ramstate = FREE;
        tick();

        // mid-access reset during a write
        do_reset();
        dWEN = 1; daddr = 32'h44; dstore = 32'h55; ramstate = BUSY;
        tick();
        #2; chk("mid_wen_before", 32'(ramWEN), 32'd1);
        nRST = 1'b0; model_reset();
        #1; chk("mid_wen_async", 32'(ramWEN), 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        #3; chk("mid_idle_wen", 32'(ramWEN), 32'd0); chk("mid_idle_addr", ramaddr, 32'd0); #1;
        @(posedge CLK); model_step(); #1;
        dWEN = 0;
        tick();

        // randomized traffic with protocol-following requesters
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (i_pend && i_done) begin
                iREN = 0; i_pend = 0;
            end else if (!i_pend && $urandom_range(2, 0) == 0) begin
                iREN = 1; iaddr = $urandom; i_pend = 1;
            end
            if (d_pend && d_done) begin
                dREN = 0; dWEN = 0; d_pend = 0;
            end else if (!d_pend && $urandom_range(1, 0) == 0) begin
                case ($urandom_range(2, 0))
                    0: begin dREN = 1; dWEN = 0; end
                    1: begin dREN = 0; dWEN = 1; end
                    default: begin dREN = 1; dWEN = 1; end
                endcase
                daddr = $urandom; dstore = $urandom; d_pend = 1;
            end
            case ($urandom_range(19, 0))
                0, 1, 2:      ramstate = FREE;
                3, 4, 5, 6, 7: ramstate = BUSY;
                8:            ramstate = ERR;
                default:      ramstate = ACCESS;
            endcase
            ramload = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
